// File: rtl/seq_divider_if.sv
// Handshake and result bundle for the sequential restoring divider.
// The master drives the request; the slave (divider) returns the results.
interface seq_divider_if #(
   parameter int WIDTH = 16,
   parameter int CW    = $clog2(WIDTH + 1)
);
   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] DIVIDEND;
   logic [WIDTH-1:0] DIVIDER;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             ready;
   logic             done;
   logic             div_by_zero;
   logic [CW-1:0]    count;

   modport master (
      output start, is_signed, DIVIDEND, DIVIDER,
      input  quotient, remainder, ready, done, div_by_zero, count
   );

   modport slave (
      input  start, is_signed, DIVIDEND, DIVIDER,
      output quotient, remainder, ready, done, div_by_zero, count
   );
endinterface

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, signed or unsigned,
// with sign correction and divide-by-zero handling in a final FIX cycle.
module seq_divider #(
   parameter int WIDTH = 16,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input logic          Clk,
   input logic          Reset,
   seq_divider_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] quo_r;
   logic [WIDTH-1:0] rem_r;
   logic [WIDTH-1:0] dvsr_r;
   logic [WIDTH-1:0] dividend_r;
   logic             q_neg_r;
   logic             r_neg_r;
   logic             zero_path_r;
   logic [CW-1:0]    count_r;
   logic [WIDTH-1:0] quotient_r;
   logic [WIDTH-1:0] remainder_r;
   logic             ready_r;
   logic             done_r;
   logic             dbz_r;

   logic             neg_a_s;
   logic             neg_b_s;
   logic [WIDTH:0]   shifted_s;
   logic [WIDTH+1:0] trial_s;
   logic             trial_ok_s;

   // Two's-complement magnitude; the most negative value maps onto itself,
   // which is exactly its unsigned magnitude.
   function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] v,
                                                input logic             neg);
      if (neg) begin
         mag_of = ~v + WIDTH'(1);
      end else begin
         mag_of = v;
      end
   endfunction

   // Operand signs and the trial subtraction of one restoring step.
   always_comb begin
      neg_a_s    = bus.is_signed & bus.DIVIDEND[WIDTH-1];
      neg_b_s    = bus.is_signed & bus.DIVIDER[WIDTH-1];
      shifted_s  = {rem_r, quo_r[WIDTH-1]};
      trial_s    = {1'b0, shifted_s} - {2'b00, dvsr_r};
      trial_ok_s = ~trial_s[WIDTH+1];
   end

   // Control FSM with working and result registers.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_r     <= IDLE;
         quo_r       <= '0;
         rem_r       <= '0;
         dvsr_r      <= '0;
         dividend_r  <= '0;
         q_neg_r     <= 1'b0;
         r_neg_r     <= 1'b0;
         zero_path_r <= 1'b0;
         count_r     <= '0;
         quotient_r  <= '0;
         remainder_r <= '0;
         ready_r     <= 1'b1;
         done_r      <= 1'b0;
         dbz_r       <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               dbz_r  <= 1'b0;
               if (bus.start) begin
                  dividend_r <= bus.DIVIDEND;
                  quo_r      <= mag_of(bus.DIVIDEND, neg_a_s);
                  dvsr_r     <= mag_of(bus.DIVIDER, neg_b_s);
                  rem_r      <= '0;
                  q_neg_r    <= neg_a_s ^ neg_b_s;
                  r_neg_r    <= neg_a_s;
                  ready_r    <= 1'b0;
                  if (bus.DIVIDER == '0) begin
                     zero_path_r <= 1'b1;
                     count_r     <= '0;
                     state_r     <= FIX;
                  end else begin
                     zero_path_r <= 1'b0;
                     count_r     <= CW'(WIDTH);
                     state_r     <= RUN;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            RUN: begin
               if (trial_ok_s) begin
                  rem_r <= trial_s[WIDTH-1:0];
               end else begin
                  rem_r <= shifted_s[WIDTH-1:0];
               end
               quo_r   <= {quo_r[WIDTH-2:0], trial_ok_s};
               count_r <= count_r - CW'(1);
               if (count_r == CW'(1)) begin
                  state_r <= FIX;
               end else begin
                  state_r <= RUN;
               end
            end
            FIX: begin
               if (zero_path_r) begin
                  quotient_r  <= {WIDTH{1'b1}};
                  remainder_r <= dividend_r;
                  dbz_r       <= 1'b1;
               end else begin
                  quotient_r  <= mag_of(quo_r, q_neg_r);
                  remainder_r <= mag_of(rem_r, r_neg_r);
                  dbz_r       <= 1'b0;
               end
               done_r  <= 1'b1;
               ready_r <= 1'b1;
               count_r <= '0;
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
               ready_r <= 1'b1;
               done_r  <= 1'b0;
               dbz_r   <= 1'b0;
               count_r <= '0;
            end
         endcase
      end
   end

   assign bus.quotient    = quotient_r;
   assign bus.remainder   = remainder_r;
   assign bus.ready       = ready_r;
   assign bus.done        = done_r;
   assign bus.div_by_zero = dbz_r;
   assign bus.count       = count_r;

endmodule

// File: tb/tb_seq_divider.sv
// Randomized self-checking bench for seq_divider against an arithmetic model
// built on the language's own division and modulo operators.
module tb_seq_divider;
   localparam int W  = 16;
   localparam int CW = $clog2(W + 1);

   logic Clk;
   logic Reset;
   int   total;
   int   bad;

   seq_divider_if #(.WIDTH(W), .CW(CW)) bus ();

   seq_divider #(.WIDTH(W), .CW(CW)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic void model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] q, output logic [W-1:0] r,
                                 output logic z);
      int sa;
      int sb;
      if (b == '0) begin
         q = '1;
         r = a;
         z = 1'b1;
      end else if (s) begin
         sa = int'($signed(a));
         sb = int'($signed(b));
         q  = W'(sa / sb);
         r  = W'(sa % sb);
         z  = 1'b0;
      end else begin
         q = a / b;
         r = a % b;
         z = 1'b0;
      end
   endfunction

   // Called at a negedge while ready: presents a request for the next edge.
   task automatic launch(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
      chk("ready_before_start", 64'(bus.ready), 64'd1);
      bus.start     = 1'b1;
      bus.is_signed = s;
      bus.DIVIDEND  = a;
      bus.DIVIDER   = b;
   endtask

   // Passes the acceptance edge, then follows the operation to its done cycle.
   // poke_at >= 0 pulses a foreign start during that RUN cycle.
   task automatic finish_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                            input int poke_at);
      logic [W-1:0] eq, er, q0, r0;
      logic         ez;
      int           n;
      int           lat;
      model(s, a, b, eq, er, ez);
      lat = (b == '0) ? 1 : W + 1;
      @(posedge Clk);
      @(negedge Clk);
      bus.start = 1'b0;
      q0 = bus.quotient;
      r0 = bus.remainder;
      n  = 0;
      while (bus.done !== 1'b1 && n < 100) begin
         if (b != '0 && n < W) begin
            chk("count_run", 64'(bus.count), 64'(W - n));
         end else begin
            chk("count_idle", 64'(bus.count), 64'd0);
         end
         chk("ready_busy", 64'(bus.ready), 64'd0);
         chk("q_hold", 64'(bus.quotient), 64'(q0));
         chk("r_hold", 64'(bus.remainder), 64'(r0));
         if (n == poke_at) begin
            bus.start    = 1'b1;
            bus.DIVIDEND = ~a;
            bus.DIVIDER  = 16'h0001;
         end else begin
            bus.start = 1'b0;
         end
         @(posedge Clk);
         @(negedge Clk);
         n++;
      end
      bus.start = 1'b0;
      chk("latency", 64'(n), 64'(lat));
      chk("quotient", 64'(bus.quotient), 64'(eq));
      chk("remainder", 64'(bus.remainder), 64'(er));
      chk("div_by_zero", 64'(bus.div_by_zero), 64'(ez));
      chk("ready_done", 64'(bus.ready), 64'd1);
      chk("count_done", 64'(bus.count), 64'd0);
   endtask

   task automatic op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
      launch(s, a, b);
      finish_op(s, a, b, -1);
      @(negedge Clk);
      chk("done_pulse", 64'(bus.done), 64'd0);
      chk("dbz_pulse", 64'(bus.div_by_zero), 64'd0);
   endtask

   initial begin
      logic         s;
      logic [W-1:0] a, b;
      int           seen;
      total         = 0;
      bad           = 0;
      bus.start     = 1'b0;
      bus.is_signed = 1'b0;
      bus.DIVIDEND  = '0;
      bus.DIVIDER   = '0;
      Reset         = 1'b1;
      #1;
      chk("rst_ready", 64'(bus.ready), 64'd1);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_q", 64'(bus.quotient), 64'd0);
      chk("rst_r", 64'(bus.remainder), 64'd0);
      chk("rst_count", 64'(bus.count), 64'd0);
      chk("rst_dbz", 64'(bus.div_by_zero), 64'd0);
      @(negedge Clk);
      @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);

      op(1'b0, 16'd100, 16'd7);
      op(1'b1, 16'hFFF9, 16'd2);
      op(1'b1, 16'd7, 16'hFFFE);
      op(1'b0, 16'hFFFF, 16'd1);
      op(1'b0, 16'd1234, 16'd0);
      op(1'b1, 16'd1234, 16'd0);
      op(1'b1, 16'h8000, 16'hFFFF);
      op(1'b1, 16'h8000, 16'd0);
      op(1'b0, 16'd5, 16'd9);

      // Foreign start during RUN is ignored and leaves nothing queued.
      launch(1'b0, 16'd1000, 16'd33);
      finish_op(1'b0, 16'd1000, 16'd33, 3);
      seen = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge Clk);
         if (bus.done === 1'b1) seen++;
      end
      chk("no_queued_op", 64'(seen), 64'd0);

      // Start held through the done cycle: back-to-back with no bubble.
      launch(1'b0, 16'd300, 16'd11);
      finish_op(1'b0, 16'd300, 16'd11, -1);
      launch(1'b1, 16'hFF00, 16'd7);
      finish_op(1'b1, 16'hFF00, 16'd7, -1);
      launch(1'b0, 16'd77, 16'd0);
      finish_op(1'b0, 16'd77, 16'd0, -1);
      @(negedge Clk);
      chk("b2b_done_drop", 64'(bus.done), 64'd0);

      // Asynchronous reset in the middle of RUN.
      launch(1'b0, 16'd999, 16'd3);
      @(posedge Clk);
      @(negedge Clk);
      bus.start = 1'b0;
      for (int i = 0; i < 5; i++) @(negedge Clk);
      chk("pre_rst_busy", 64'(bus.ready), 64'd0);
      Reset = 1'b1;
      #1;
      chk("mid_rst_ready", 64'(bus.ready), 64'd1);
      chk("mid_rst_done", 64'(bus.done), 64'd0);
      chk("mid_rst_q", 64'(bus.quotient), 64'd0);
      chk("mid_rst_r", 64'(bus.remainder), 64'd0);
      chk("mid_rst_count", 64'(bus.count), 64'd0);
      @(negedge Clk);
      Reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge Clk);
         if (bus.done === 1'b1) seen++;
      end
      chk("no_done_after_rst", 64'(seen), 64'd0);
      op(1'b0, 16'd50, 16'd5);

      // Randomized operations with a bias towards corner operands.
      for (int i = 0; i < 150; i++) begin
         s = 1'(($urandom & 32'd1));
         a = W'($urandom);
         b = W'($urandom);
         case ($urandom_range(0, 7))
            0: b = '0;
            1: b = 16'hFFFF;
            2: a = 16'h8000;
            3: b = W'($urandom_range(1, 15));
            default: ;
         endcase
         op(s, a, b);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width; legal range 2..64.
REQ-002 Parameter CW, default $clog2(WIDTH+1), width of count.
REQ-003 Clk  input  1  rising-edge clock; the only clock.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request a division; sampled only while ready=1.
REQ-006 is_signed  input  1  1 = two's-complement operation, 0 = unsigned; sampled with start.
REQ-007 DIVIDEND  input  WIDTH  numerator; sampled with start.
REQ-008 DIVIDER  input  WIDTH  denominator; sampled with start.
REQ-009 quotient  output  WIDTH  result quotient, registered.
REQ-010 remainder  output  WIDTH  result remainder, registered.
REQ-011 ready  output  1  high when IDLE and able to accept start.
REQ-012 done  output  1  one-cycle pulse; the result is valid on the same cycle.
REQ-013 div_by_zero  output  1  set with done when DIVIDER was 0.
REQ-014 count  output  CW  iterations remaining; 0 when not in RUN.

Function
REQ-015 States: IDLE, RUN, FIX; ready = (state==IDLE).
REQ-016 Acceptance: edge with state IDLE and start=1; DIVIDEND, DIVIDER and is_signed are latched into working registers; other inputs are ignored while not IDLE.
REQ-017 Acceptance with DIVIDER!=0: go to RUN; count=WIDTH; working remainder=0.
REQ-018 Acceptance with DIVIDER=0: go to FIX directly, with the zero-divide path selected.
REQ-019 Signed mode: the working operands are the magnitudes of the inputs; the quotient sign is the XOR of the operand signs; the remainder sign is the sign of DIVIDEND.
REQ-020 RUN, each edge, is one restoring step.
  - Shift the {remainder, dividend} pair left by 1.
  - Trial-subtract the magnitude divisor from the upper WIDTH+1 bits.
  - If the result is non-negative, keep it and set quotient LSB=1; else restore and set LSB=0.
  - Decrement count.
REQ-021 RUN -> FIX on the edge where count goes 1 -> 0; RUN lasts exactly WIDTH edges.
REQ-022 FIX, one edge, then IDLE.
  - Sign-correct the results and load them into quotient/remainder.
  - Set done=1; set div_by_zero per the path taken.
REQ-023 Latency: done is high in the cycle after edge WIDTH+1 counted from acceptance (edge 0); zero-divide latency is 1 edge.
REQ-024 done and div_by_zero are cleared on the next edge; quotient/remainder hold until the next FIX.
REQ-025 Intermediate RUN values never appear on quotient/remainder.
REQ-026 Zero-divide result: quotient=all ones, remainder=DIVIDEND unchanged (both modes), div_by_zero=1.
REQ-027 Signed most-negative / -1: quotient=100..0 (wraps), remainder=0, no flag.
REQ-028 Division truncates toward zero; |remainder| < |divisor|.
REQ-029 start in the done cycle (state IDLE) is accepted; done drops on that edge; back-to-back operations have no bubble.
REQ-030 start while RUN/FIX has no effect and is not queued.

Reset
REQ-031 Reset=1 forces, asynchronously: state=IDLE, quotient=0, remainder=0, done=0, div_by_zero=0, count=0, ready=1.
REQ-032 Reset mid-operation abandons the operation; no done pulse follows; the first edge after release can accept start.

Verification
REQ-033 WIDTH=16, unsigned 100/7 -> quotient=14, remainder=2, done exactly 17 cycles after acceptance, count 16..1 in RUN.
REQ-034 Signed -7/2 -> 0xFFFD, 0xFFFF; signed 7/-2 -> 0xFFFD, 0x0001; unsigned 0xFFFF/1 -> 0xFFFF, 0x0000.
REQ-035 1234/0 (either mode) -> quotient=0xFFFF, remainder=1234, div_by_zero=1 with done 1 cycle after acceptance.
REQ-036 Signed 0x8000/0xFFFF -> quotient=0x8000, remainder=0, div_by_zero=0.
REQ-037 start pulsed at RUN cycle 3 -> ignored, single done; start held during done -> second result 17 cycles later.
REQ-038 Reset at RUN cycle 5 -> ready=1, done=0, outputs 0 at once; a fresh 50/5 then gives 10, 0.
